// File: rtl/fpcvt_seq_ctrl.sv
// Sequential 12-bit linear to S/E[2:0]/F[3:0] float converter with valid/ready handshakes.
// Define FPCTL_ROUND_EN for round-half-up; otherwise the significand is truncated.
module fpcvt_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] D,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        S,
    output logic [2:0]  E,
    output logic [3:0]  F,
    output logic        sat
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    // Magnitude bit 11 is always zero, so only bits 10:0 are kept.
    logic [10:0] mag_q, mag_d;
    logic [2:0]  e_q, e_d;
    logic        sign_q, sign_d;
    logic        satf_q, satf_d;
    logic        s_q, s_d;
    logic [2:0]  exp_q, exp_d;
    logic [3:0]  frac_q, frac_d;
    logic        sat_q, sat_d;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign S         = s_q;
    assign E         = exp_q;
    assign F         = frac_q;
    assign sat       = sat_q;

    // Next-state and datapath update for the conversion sequence.
    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        e_d     = e_q;
        sign_d  = sign_q;
        satf_d  = satf_q;
        s_d     = s_q;
        exp_d   = exp_q;
        frac_d  = frac_q;
        sat_d   = sat_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid == 1'b1) begin
                    sign_d = D[11];
                    e_d    = 3'd7;
                    if (D == 12'h800) begin
                        mag_d  = 11'h7FF;
                        satf_d = 1'b1;
                    end else if (D[11] == 1'b1) begin
                        // |D| = 2048 - D[10:0], which fits 11 bits once -2048 is excluded.
                        mag_d  = 11'd0 - D[10:0];
                        satf_d = 1'b0;
                    end else begin
                        mag_d  = D[10:0];
                        satf_d = 1'b0;
                    end
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if ((e_q != 3'd0) && (mag_q[10] == 1'b0)) begin
                    mag_d   = {mag_q[9:0], 1'b0};
                    e_d     = e_q - 3'd1;
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                s_d = sign_q;
`ifdef FPCTL_ROUND_EN
                if (mag_q[6] == 1'b1) begin
                    if (mag_q[10:7] != 4'hF) begin
                        frac_d = mag_q[10:7] + 4'd1;
                        exp_d  = e_q;
                        sat_d  = satf_q;
                    end else if (e_q != 3'd7) begin
                        frac_d = 4'b1000;
                        exp_d  = e_q + 3'd1;
                        sat_d  = satf_q;
                    end else begin
                        frac_d = 4'hF;
                        exp_d  = 3'd7;
                        sat_d  = 1'b1;
                    end
                end else begin
                    frac_d = mag_q[10:7];
                    exp_d  = e_q;
                    sat_d  = satf_q;
                end
`else
                frac_d = mag_q[10:7];
                exp_d  = e_q;
                sat_d  = satf_q;
`endif
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready == 1'b1) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, working registers and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mag_q   <= 11'd0;
            e_q     <= 3'd0;
            sign_q  <= 1'b0;
            satf_q  <= 1'b0;
            s_q     <= 1'b0;
            exp_q   <= 3'd0;
            frac_q  <= 4'd0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            e_q     <= e_d;
            sign_q  <= sign_d;
            satf_q  <= satf_d;
            s_q     <= s_d;
            exp_q   <= exp_d;
            frac_q  <= frac_d;
            sat_q   <= sat_d;
        end
    end

endmodule

// File: tb/tb_fpcvt_seq_ctrl.sv
// Self-checking bench for fpcvt_seq_ctrl: directed vectors, random samples, back-pressure, reset.
// Expected results follow FPCTL_ROUND_EN the same way the design does.
module tb_fpcvt_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] D;
    logic        out_valid;
    logic        out_ready;
    logic        S;
    logic [2:0]  E;
    logic [3:0]  F;
    logic        sat;

    int total = 0;
    int bad   = 0;

    fpcvt_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .E         (E),
        .F         (F),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    // Reference: normalise |D| into [1024,2047] with at most 7 doublings, then round.
    task automatic model(input logic [11:0] d, output logic [8:0] res, output int lat);
        int v, mag, n, sh, f, r, e;
        bit satf;
        v    = int'($signed(d));
        satf = (v == -2048);
        mag  = satf ? 2047 : ((v < 0) ? -v : v);
        n    = 0;
        while (n < 7 && mag < (1024 >> n)) n++;
        e  = 7 - n;
        sh = mag << n;
        f  = (sh >> 7) & 15;
        r  = (sh >> 6) & 1;
`ifdef FPCTL_ROUND_EN
        if (r == 1) begin
            if (f < 15) f = f + 1;
            else if (e < 7) begin e = e + 1; f = 8; end
            else satf = 1'b1;
        end
`endif
        res = {d[11], 3'(e), 4'(f), satf};
        lat = n + 2;
    endtask

    task automatic convert(input logic [11:0] d, input int hold, input string name);
        logic [8:0] exp_res;
        int exp_lat, lat, w;
        model(d, exp_res, exp_lat);
        w = 0;
        while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
        out_ready = (hold == 0);
        D         = d;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        D        = 12'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        total++;
        if (out_valid !== 1'b1) begin
            bad++; $display("FAIL %s timeout: out_valid=%b required 1 (D=%h)", name, out_valid, d);
        end
        total++;
        if (lat !== exp_lat) begin
            bad++; $display("FAIL %s latency: got %0d required %0d (D=%h)", name, lat, exp_lat, d);
        end
        total++;
        if ({S, E, F, sat} !== exp_res) begin
            bad++; $display("FAIL %s result: got S=%b E=%0d F=%b sat=%b required S=%b E=%0d F=%b sat=%b (D=%h)",
                            name, S, E, F, sat, exp_res[8], exp_res[7:5], exp_res[4:1], exp_res[0], d);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {S, E, F, sat} !== exp_res) begin
                bad++; $display("FAIL %s hold%0d: got v=%b rdy=%b res=%h required v=1 rdy=0 res=%h",
                                name, i, out_valid, in_ready, {S, E, F, sat}, exp_res);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL %s release: got out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; D = 12'd0;
        #1;
        total++;
        if ({S, E, F, sat, out_valid, in_ready} !== 11'b0000_0000_001) begin
            bad++; $display("FAIL reset_in: got %b required 00000000001", {S, E, F, sat, out_valid, in_ready});
        end
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({S, E, F, sat, out_valid, in_ready} !== 11'b0000_0000_001) begin
            bad++; $display("FAIL reset_out: got %b required 00000000001", {S, E, F, sat, out_valid, in_ready});
        end
    endtask

    task automatic test_directed();
        convert(12'h000, 0, "zero");
        convert(12'd422, 0, "d422");
        convert(12'd46,  0, "d46");
        convert(12'd125, 0, "d125");
        convert(12'h800, 0, "neg2048");
        convert(12'hFFF, 0, "neg1");
        convert(12'h7FF, 0, "max_pos");
        convert(12'h801, 0, "neg2047");
    endtask

    task automatic test_backpressure();
        convert(12'd125, 5, "backpressure");
    endtask

    task automatic test_reset_mid_scan();
        out_ready = 1'b1;
        D         = 12'd46;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b0;
        #1;
        total++;
        if ({S, E, F, sat, out_valid, in_ready} !== 11'b0000_0000_001) begin
            bad++; $display("FAIL mid_reset: got %b required 00000000001", {S, E, F, sat, out_valid, in_ready});
        end
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++; $display("FAIL mid_reset_idle: got out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
            end
        end
        convert(12'd422, 0, "after_reset");
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            convert(12'($urandom), $urandom_range(0, 2), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_scan();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
